// File: rtl/sap_pkg.sv
// Shared definitions for the SAP microcode sequencer: opcodes, control-bit
// positions and the two fetch words every instruction starts with.
package sap_pkg;

    localparam int CW_W = 16;
    typedef logic [CW_W-1:0] cw_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_LDI = 4'h5,
        OP_JMP = 4'h6,
        OP_JC  = 4'h7,
        OP_JZ  = 4'h8,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    // Bit positions inside the control word, MSB first.
    localparam int B_HLT  = 15;
    localparam int B_MI   = 14;
    localparam int B_RI   = 13;
    localparam int B_RO   = 12;
    localparam int B_IO   = 11;
    localparam int B_II   = 10;
    localparam int B_AI   = 9;
    localparam int B_AO   = 8;
    localparam int B_SUMO = 7;
    localparam int B_SUB  = 6;
    localparam int B_BI   = 5;
    localparam int B_OI   = 4;
    localparam int B_CE   = 3;
    localparam int B_CO   = 2;
    localparam int B_J    = 1;
    localparam int B_FI   = 0;

    localparam cw_t CW_HLT  = cw_t'(1 << B_HLT);
    localparam cw_t CW_MI   = cw_t'(1 << B_MI);
    localparam cw_t CW_RI   = cw_t'(1 << B_RI);
    localparam cw_t CW_RO   = cw_t'(1 << B_RO);
    localparam cw_t CW_IO   = cw_t'(1 << B_IO);
    localparam cw_t CW_II   = cw_t'(1 << B_II);
    localparam cw_t CW_AI   = cw_t'(1 << B_AI);
    localparam cw_t CW_AO   = cw_t'(1 << B_AO);
    localparam cw_t CW_SUMO = cw_t'(1 << B_SUMO);
    localparam cw_t CW_SUB  = cw_t'(1 << B_SUB);
    localparam cw_t CW_BI   = cw_t'(1 << B_BI);
    localparam cw_t CW_OI   = cw_t'(1 << B_OI);
    localparam cw_t CW_CE   = cw_t'(1 << B_CE);
    localparam cw_t CW_CO   = cw_t'(1 << B_CO);
    localparam cw_t CW_J    = cw_t'(1 << B_J);
    localparam cw_t CW_FI   = cw_t'(1 << B_FI);

    localparam cw_t CW_T0 = CW_MI | CW_CO;
    localparam cw_t CW_T1 = CW_RO | CW_II | CW_CE;

endpackage

// File: rtl/sap_ucode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word.
// This is the single place where instruction behaviour is defined.
module sap_ucode_rom
    import sap_pkg::*;
#(
    parameter int OPC_W  = 4,
    parameter int STEP_W = 3
) (
    input  logic [OPC_W-1:0]  i_opcode,
    input  logic [STEP_W-1:0] i_step,
    input  logic              i_flag_c,
    input  logic              i_flag_z,
    output cw_t               o_word
);

    logic [3:0] w_opc;
    logic [3:0] w_step;

    assign w_opc  = 4'(i_opcode);
    assign w_step = 4'(i_step);

    always_comb begin
        o_word = '0;
        if (w_step == 4'd0) begin
            o_word = CW_T0;
        end else if (w_step == 4'd1) begin
            o_word = CW_T1;
        end else begin
            case (w_opc)
                OP_LDA: begin
                    if (w_step == 4'd2)      o_word = CW_MI | CW_IO;
                    else if (w_step == 4'd3) o_word = CW_RO | CW_AI;
                end
                OP_ADD, OP_SUB: begin
                    if (w_step == 4'd2)      o_word = CW_MI | CW_IO;
                    else if (w_step == 4'd3) o_word = CW_RO | CW_BI;
                    else if (w_step == 4'd4) begin
                        o_word = CW_SUMO | CW_AI | CW_FI;
                        if (w_opc == OP_SUB) o_word = o_word | CW_SUB;
                    end
                end
                OP_STA: begin
                    if (w_step == 4'd2)      o_word = CW_MI | CW_IO;
                    else if (w_step == 4'd3) o_word = CW_AO | CW_RI;
                end
                OP_LDI: if (w_step == 4'd2) o_word = CW_IO | CW_AI;
                OP_JMP: if (w_step == 4'd2) o_word = CW_IO | CW_J;
                // A jump not taken leaves T2 empty so early-end can skip it.
                OP_JC:  if (w_step == 4'd2 && i_flag_c) o_word = CW_IO | CW_J;
                OP_JZ:  if (w_step == 4'd2 && i_flag_z) o_word = CW_IO | CW_J;
                OP_OUT: if (w_step == 4'd2) o_word = CW_AO | CW_OI;
                OP_HLT: if (w_step == 4'd2) o_word = CW_HLT;
                default: o_word = '0;
            endcase
        end
    end

endmodule

// File: rtl/sap_microseq.sv
// Microcode sequencer top: T-state counter, early end-of-instruction,
// sticky halt and programming-mode hold, with registered control word.
module sap_microseq
    import sap_pkg::*;
#(
    parameter int  INSN_W    = 8,
    parameter int  OPC_W     = 4,
    parameter int  STEPS     = 5,
    parameter int  EARLY_END = 1,
    localparam int STEP_W    = $clog2(STEPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [INSN_W-1:0] insn,
    input  logic              flag_c,
    input  logic              flag_z,
    input  logic              prog_mode,
    output logic [CW_W-1:0]   ctrl,
    output logic [STEP_W-1:0] step,
    output logic              halted
);

    logic [STEP_W-1:0] r_step;
    logic [STEP_W-1:0] w_step_next;
    logic [STEP_W-1:0] w_cand_step;
    cw_t               r_ctrl;
    cw_t               w_ctrl_next;
    cw_t               w_cand_word;
    logic              r_halted;
    logic              w_halted_next;
    logic              r_prog_hold;
    logic              w_prog_hold_next;
    logic [OPC_W-1:0]  w_opcode;
    logic              w_insn_unused;

    assign w_opcode      = insn[INSN_W-1 -: OPC_W];
    assign w_insn_unused = ^insn[INSN_W-OPC_W-1:0];

    assign w_cand_step = (r_step == STEP_W'(STEPS - 1)) ? '0 : r_step + STEP_W'(1);

    sap_ucode_rom #(
        .OPC_W  (OPC_W),
        .STEP_W (STEP_W)
    ) u_rom (
        .i_opcode (w_opcode),
        .i_step   (w_cand_step),
        .i_flag_c (flag_c),
        .i_flag_z (flag_z),
        .o_word   (w_cand_word)
    );

    always_comb begin
        w_step_next      = r_step;
        w_ctrl_next      = r_ctrl;
        w_halted_next    = r_halted;
        w_prog_hold_next = r_prog_hold;
        if (r_halted) begin
            w_ctrl_next = CW_HLT;
        end else if (prog_mode) begin
            w_step_next      = '0;
            w_ctrl_next      = CW_HLT;
            w_prog_hold_next = 1'b1;
        end else if (r_prog_hold) begin
            // One clean T0 cycle after programming so fetch restarts from scratch.
            w_step_next      = '0;
            w_ctrl_next      = CW_T0;
            w_prog_hold_next = 1'b0;
        end else if (w_cand_word[B_HLT]) begin
            w_step_next   = w_cand_step;
            w_ctrl_next   = CW_HLT;
            w_halted_next = 1'b1;
        end else if ((EARLY_END != 0) && (w_cand_word == '0)) begin
            w_step_next = '0;
            w_ctrl_next = CW_T0;
        end else begin
            w_step_next = w_cand_step;
            w_ctrl_next = w_cand_word;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_step      <= '0;
            r_ctrl      <= CW_T0;
            r_halted    <= 1'b0;
            r_prog_hold <= 1'b0;
        end else begin
            r_step      <= w_step_next;
            r_ctrl      <= w_ctrl_next;
            r_halted    <= w_halted_next;
            r_prog_hold <= w_prog_hold_next;
        end
    end

    assign ctrl   = r_ctrl;
    assign step   = r_step;
    assign halted = r_halted;

endmodule

// File: tb/tb_sap_microseq.sv
// Randomised self-checking bench for sap_microseq: a per-instruction word-list
// model drives expectations for an early-end instance and a fixed-length instance.
module tb_sap_microseq;

    localparam logic [15:0] HLT  = 16'h8000;
    localparam logic [15:0] MI   = 16'h4000;
    localparam logic [15:0] RI   = 16'h2000;
    localparam logic [15:0] RO   = 16'h1000;
    localparam logic [15:0] IO   = 16'h0800;
    localparam logic [15:0] II   = 16'h0400;
    localparam logic [15:0] AI   = 16'h0200;
    localparam logic [15:0] AO   = 16'h0100;
    localparam logic [15:0] SUMO = 16'h0080;
    localparam logic [15:0] SUBB = 16'h0040;
    localparam logic [15:0] BI   = 16'h0020;
    localparam logic [15:0] OI   = 16'h0010;
    localparam logic [15:0] CE   = 16'h0008;
    localparam logic [15:0] CO   = 16'h0004;
    localparam logic [15:0] J    = 16'h0002;
    localparam logic [15:0] FI   = 16'h0001;
    localparam logic [15:0] T0   = MI | CO;
    localparam logic [15:0] T1   = RO | II | CE;

    logic        clk;
    logic        rst_a, rst_b;
    logic [7:0]  insn_a, insn_b;
    logic        flag_c, flag_z;
    logic        prog_mode_a, prog_mode_b;
    logic [15:0] ctrl_a, ctrl_b;
    logic [2:0]  step_a, step_b;
    logic        halted_a, halted_b;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_q[$];
    bit          exp_halt;

    sap_microseq #(.STEPS(5), .EARLY_END(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .insn      (insn_a),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .prog_mode (prog_mode_a),
        .ctrl      (ctrl_a),
        .step      (step_a),
        .halted    (halted_a)
    );

    sap_microseq #(.STEPS(6), .EARLY_END(0)) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .insn      (insn_b),
        .flag_c    (flag_c),
        .flag_z    (flag_z),
        .prog_mode (prog_mode_b),
        .ctrl      (ctrl_b),
        .step      (step_b),
        .halted    (halted_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Whole-instruction word list from the instruction table.
    task automatic build_seq(input logic [7:0] ins, input bit c, input bit z,
                             input bit early, input int steps);
        exp_q.delete();
        exp_halt = 1'b0;
        exp_q.push_back(T0);
        exp_q.push_back(T1);
        case (ins[7:4])
            4'h1: begin exp_q.push_back(MI | IO); exp_q.push_back(RO | AI); end
            4'h2: begin
                exp_q.push_back(MI | IO); exp_q.push_back(RO | BI);
                exp_q.push_back(SUMO | AI | FI);
            end
            4'h3: begin
                exp_q.push_back(MI | IO); exp_q.push_back(RO | BI);
                exp_q.push_back(SUMO | SUBB | AI | FI);
            end
            4'h4: begin exp_q.push_back(MI | IO); exp_q.push_back(AO | RI); end
            4'h5: exp_q.push_back(IO | AI);
            4'h6: exp_q.push_back(IO | J);
            4'h7: if (c) exp_q.push_back(IO | J);
            4'h8: if (z) exp_q.push_back(IO | J);
            4'hE: exp_q.push_back(AO | OI);
            4'hF: begin exp_q.push_back(HLT); exp_halt = 1'b1; end
            default: ;
        endcase
        if (!early && !exp_halt)
            while (exp_q.size() < steps) exp_q.push_back(16'h0000);
    endtask

    // Entered at a posedge with the selected DUT sitting in T0; leaves it in T0 again
    // (or halted).
    task automatic run_insn(input bit sel, input logic [7:0] ins, input bit c, input bit z);
        logic [15:0] o_ctrl;
        logic [2:0]  o_step;
        logic        o_halt;
        build_seq(ins, c, z, !sel, sel ? 6 : 5);
        if (sel) insn_b = ins; else insn_a = ins;
        flag_c = c;
        flag_z = z;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) @(posedge clk);
            o_ctrl = sel ? ctrl_b : ctrl_a;
            o_step = sel ? step_b : step_a;
            o_halt = sel ? halted_b : halted_a;
            $display("%s insn=%02h c=%0d z=%0d T%0d ctrl=%04h step=%0d halted=%0d",
                     sel ? "B" : "A", ins, c, z, k, o_ctrl, o_step, o_halt);
            check_val($sformatf("%s_op%02h_T%0d_ctrl", sel ? "B" : "A", ins, k), 32'(o_ctrl), 32'(exp_q[k]));
            check_val($sformatf("%s_op%02h_T%0d_step", sel ? "B" : "A", ins, k), 32'(o_step), k);
            check_val($sformatf("%s_op%02h_T%0d_halt", sel ? "B" : "A", ins, k), 32'(o_halt),
                      32'(exp_halt && (k == exp_q.size() - 1)));
        end
        if (!exp_halt) @(posedge clk);
    endtask

    initial begin
        rst_a = 1'b0; rst_b = 1'b0;
        insn_a = 8'h00; insn_b = 8'h00;
        flag_c = 1'b0; flag_z = 1'b0;
        prog_mode_a = 1'b0; prog_mode_b = 1'b0;

        repeat (2) @(posedge clk);
        check_val("reset_ctrl", 32'(ctrl_a), 32'(T0));
        check_val("reset_step", 32'(step_a), 0);
        check_val("reset_halted", 32'(halted_a), 0);
        rst_a = 1'b1;

        // Directed coverage of every opcode and both jump outcomes.
        run_insn(0, 8'h1E, 0, 0);
        run_insn(0, 8'h2F, 0, 0);
        run_insn(0, 8'h3F, 0, 0);
        run_insn(0, 8'h71, 1, 0);
        run_insn(0, 8'h71, 0, 1);
        run_insn(0, 8'h82, 0, 1);
        run_insn(0, 8'h82, 1, 0);
        run_insn(0, 8'h00, 0, 0);
        run_insn(0, 8'h5A, 0, 0);
        run_insn(0, 8'h4C, 0, 0);
        run_insn(0, 8'h63, 0, 0);
        run_insn(0, 8'hE0, 0, 0);
        run_insn(0, 8'h9A, 1, 1);
        run_insn(0, 8'hC5, 1, 1);

        for (int i = 0; i < 60; i++)
            run_insn(0, {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))},
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Programming mode raised during ADD T3.
        insn_a = 8'h2F;
        check_val("pm_T0", 32'(ctrl_a), 32'(T0));
        @(posedge clk);
        check_val("pm_T1", 32'(ctrl_a), 32'(T1));
        @(posedge clk);
        check_val("pm_T2", 32'(ctrl_a), 32'(MI | IO));
        @(posedge clk);
        check_val("pm_T3", 32'(ctrl_a), 32'(RO | BI));
        prog_mode_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            $display("A prog_mode=1 cyc=%0d ctrl=%04h step=%0d halted=%0d", i, ctrl_a, step_a, halted_a);
            check_val("pm_hold_ctrl", 32'(ctrl_a), 32'(HLT));
            check_val("pm_hold_step", 32'(step_a), 0);
            check_val("pm_hold_halted", 32'(halted_a), 0);
        end
        prog_mode_a = 1'b0;
        @(posedge clk);
        check_val("pm_drop_ctrl", 32'(ctrl_a), 32'(T0));
        check_val("pm_drop_step", 32'(step_a), 0);
        run_insn(0, 8'h1E, 0, 0);

        // Asynchronous reset in the middle of ADD.
        insn_a = 8'h2F;
        @(posedge clk);
        @(posedge clk);
        #2 rst_a = 1'b0;
        #1;
        check_val("async_rst_ctrl", 32'(ctrl_a), 32'(T0));
        check_val("async_rst_step", 32'(step_a), 0);
        check_val("async_rst_halted", 32'(halted_a), 0);
        @(posedge clk);
        rst_a = 1'b1;
        run_insn(0, 8'h2F, 0, 0);

        // Sticky halt ignores instruction and flag changes.
        run_insn(0, 8'hF0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            insn_a = 8'($urandom);
            flag_c = 1'($urandom_range(0, 1));
            flag_z = 1'($urandom_range(0, 1));
            @(posedge clk);
            $display("A halted cyc=%0d insn=%02h ctrl=%04h step=%0d halted=%0d", i, insn_a, ctrl_a, step_a, halted_a);
            check_val("halt_ctrl", 32'(ctrl_a), 32'(HLT));
            check_val("halt_step", 32'(step_a), 2);
            check_val("halt_flag", 32'(halted_a), 1);
        end
        #2 rst_a = 1'b0;
        #1;
        check_val("halt_rst_ctrl", 32'(ctrl_a), 32'(T0));
        check_val("halt_rst_halted", 32'(halted_a), 0);
        @(posedge clk);
        rst_a = 1'b1;
        run_insn(0, 8'h1E, 0, 0);

        // Fixed-length instance: STEPS=6, no early end.
        check_val("B_reset_ctrl", 32'(ctrl_b), 32'(T0));
        check_val("B_reset_step", 32'(step_b), 0);
        rst_b = 1'b1;
        run_insn(1, 8'h50, 0, 0);
        for (int i = 0; i < 15; i++)
            run_insn(1, {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))},
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
